alu_operand_entry: RTL and testbench
====================================

// Module: alu_operand_entry
// PURPOSE
//  Operator-input front end of the ALU board: debounces three push-buttons, builds 32-bit
//  operands A and B nibble by nibble from 4 slide switches, and latches the ALU opcode.
//  Captures the combinational ALU's 64-bit result into a register.
//  Drives ALU_out, A4b, B4b and Disp_flag straight into the display stage.
// PARAMETERS
//  DEB_BITS   20   debounce counter width; an input must be stable for 2**DEB_BITS clk cycles
// PORTS
//  clk        in   1   system clock; all logic on its rising edge
//  rstn       in   1   reset, asynchronous, active-low
//  sw_nib     in   4   nibble value being keyed in
//  sw_op      in   3   ALU opcode selection switches
//  btn_enter  in   1   raw button: commit nibble / restart entry
//  btn_exec   in   1   raw button: run the ALU
//  btn_page   in   1   raw button: toggle which 32-bit half of the result is shown
//  alu_res    in   64  combinational ALU result for (opA, opB, alu_op)
//  opA        out  32  operand A register
//  opB        out  32  operand B register
//  alu_op     out  3   latched opcode
//  ALU_out    out  64  latched ALU result
//  A4b        out  4   nibble of A shown as in-progress
//  B4b        out  4   nibble of B shown as in-progress
//  Disp_flag  out  1   1 = show ALU_out[63:32], 0 = show ALU_out[31:0]
//  busy       out  1   high while in S_RUN
//  state      out  2   FSM state: 0 S_A, 1 S_B, 2 S_RUN, 3 S_SHOW
// BEHAVIOUR
//  Reset (async, rstn=0): opA=opB=0, alu_op=0, ALU_out=0, Disp_flag=0, state=S_A, nib_cnt=0,
//   debounce counters and synchronisers cleared, busy=0.
//   Reset mid-operation discards everything. No partial result survives.
//  Debounce, per button:
//   - 2-FF synchroniser, then a counter that restarts on any change of the synced level.
//   - Debounced level updates when the counter saturates.
//   - A 0->1 debounced edge gives a 1-cycle pulse (enter_p, exec_p, page_p).
//   - Latency from a stable press to its pulse is 2 + 2**DEB_BITS cycles.
//  page_p: toggles Disp_flag in every state. Independent of the FSM.
//  nib_cnt: 3-bit counter of nibbles committed to the current operand.
//  FSM:
//   S_A:
//    - enter_p: opA <= {opA[27:0], sw_nib}; nib_cnt++.
//    - enter_p with nib_cnt==7: additionally nib_cnt<=0 and go to S_B (8th nibble completes A).
//   S_B: same rules applied to opB. The 8th enter_p stays in S_B with nib_cnt=0 (B complete).
//   S_A or S_B, exec_p:
//    - alu_op <= sw_op, nib_cnt <= 0, go to S_RUN.
//    - Partially entered operands are used as-is.
//    - If exec_p and enter_p occur in the same cycle, exec wins and the nibble is dropped.
//   S_RUN: exactly 2 cycles, busy=1.
//    - Cycle 1 lets alu_res settle on the new alu_op.
//    - Cycle 2 does ALU_out <= alu_res, then goes to S_SHOW.
//    - enter_p and exec_p are ignored in S_RUN.
//   S_SHOW: ALU_out held.
//    - exec_p: re-run with alu_op <= sw_op (back to S_RUN, operands kept).
//    - enter_p: opA <= 0, opB <= 0, nib_cnt <= 0, go to S_A. ALU_out stays until the next run.
//  A4b/B4b (combinational from registers and switches):
//   - S_A: A4b=sw_nib, B4b=opB[3:0].
//   - S_B: A4b=opA[3:0], B4b=sw_nib.
//   - S_RUN/S_SHOW: A4b=opA[3:0], B4b=opB[3:0].
//  Arithmetic: shifting into an operand drops its top nibble. nib_cnt wraps 7->0 only as
//   described above. ALU_out is a plain 64-bit capture with no width conversion.
// TESTING (bench uses DEB_BITS=2; a "press" = high >=8 cycles, then low >=8 cycles)
//  1. Reset: rstn=0 with buttons bouncing -> every output 0, state=0.
//     rstn=1 -> no spurious pulses.
//  2. Bounce: btn_enter toggling every cycle for 10 cycles, then steady high -> exactly one
//     enter_p, 2+4 cycles after the level goes steady.
//  3. Entry: keys 1,2,3,4,5,6,7,8 with enter -> opA=32'h12345678, state=S_B.
//     Keys 0,0,0,A with enter, then exec with sw_op=3 -> opB=32'h0000000A, alu_op=3.
//  4. Run: from test 3 with alu_res=64'hDEAD_BEEF_0000_0001 -> busy=1 for 2 cycles.
//     ALU_out equals that value on cycle 2 exit; state=S_SHOW.
//     page press -> Disp_flag 0->1; second press -> 0.
//  5. Collision: enter_p and exec_p in the same cycle in S_A -> opA unchanged, state=S_RUN.
//     enter in S_SHOW -> opA=opB=0, ALU_out kept.
//  6. Reset mid-run: rstn=0 during S_RUN cycle 1 -> ALU_out=0, state=S_A.
//     Operation resumes cleanly after release.

Source files
------------

// File: rtl/alu_operand_entry.sv
// Operator front end for the ALU board: debounced buttons, nibble-wise operand entry,
// opcode latch and result capture feeding the display stage.
module alu_operand_entry #(
  parameter int unsigned DEB_BITS = 20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  sw_nib,
  input  logic [2:0]  sw_op,
  input  logic        btn_enter,
  input  logic        btn_exec,
  input  logic        btn_page,
  input  logic [63:0] alu_res,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic [2:0]  alu_op,
  output logic [63:0] ALU_out,
  output logic [3:0]  A4b,
  output logic [3:0]  B4b,
  output logic        Disp_flag,
  output logic        busy,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_RUN  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  // Button index: 0 enter, 1 exec, 2 page
  logic [2:0]          w_btn;
  logic [2:0]          r_sync1;
  logic [2:0]          r_sync2;
  logic [2:0]          r_deb;
  logic [DEB_BITS-1:0] r_cnt [3];
  logic [2:0]          w_pulse;
  logic                w_enter_p;
  logic                w_exec_p;
  logic                w_page_p;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_opA;
  logic [31:0] w_opA_nxt;
  logic [31:0] r_opB;
  logic [31:0] w_opB_nxt;
  logic [2:0]  r_op;
  logic [2:0]  w_op_nxt;
  logic [63:0] r_out;
  logic [63:0] w_out_nxt;
  logic [2:0]  r_nib;
  logic [2:0]  w_nib_nxt;
  logic        r_run2;
  logic        w_run2_nxt;
  logic        r_disp;

  assign w_btn = {btn_page, btn_exec, btn_enter};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int unsigned i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        // sync1 differing from sync2 means the synced level changes this edge
        if (r_sync1[i] != r_sync2[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] != '1)      r_cnt[i] <= r_cnt[i] + DEB_BITS'(1);
        if (r_cnt[i] == '1)           r_deb[i] <= r_sync2[i];
      end
    end
  end

  always_comb begin
    w_pulse = '0;
    for (int unsigned i = 0; i < 3; i++)
      w_pulse[i] = (r_cnt[i] == '1) && r_sync2[i] && !r_deb[i];
  end

  assign w_enter_p = w_pulse[0];
  assign w_exec_p  = w_pulse[1];
  assign w_page_p  = w_pulse[2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_A;
      r_opA   <= '0;
      r_opB   <= '0;
      r_op    <= '0;
      r_out   <= '0;
      r_nib   <= '0;
      r_run2  <= 1'b0;
      r_disp  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_opA   <= w_opA_nxt;
      r_opB   <= w_opB_nxt;
      r_op    <= w_op_nxt;
      r_out   <= w_out_nxt;
      r_nib   <= w_nib_nxt;
      r_run2  <= w_run2_nxt;
      r_disp  <= r_disp ^ w_page_p;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_opA_nxt   = r_opA;
    w_opB_nxt   = r_opB;
    w_op_nxt    = r_op;
    w_out_nxt   = r_out;
    w_nib_nxt   = r_nib;
    w_run2_nxt  = 1'b0;
    case (r_state)
      S_A, S_B: begin
        if (w_exec_p) begin
          w_op_nxt    = sw_op;
          w_nib_nxt   = '0;
          w_state_nxt = S_RUN;
        end else if (w_enter_p) begin
          if (r_state == S_A) w_opA_nxt = {r_opA[27:0], sw_nib};
          else                w_opB_nxt = {r_opB[27:0], sw_nib};
          // 3-bit increment wraps 7->0 on the eighth nibble
          w_nib_nxt = r_nib + 3'd1;
          if (r_nib == 3'd7 && r_state == S_A) w_state_nxt = S_B;
        end
      end
      S_RUN: begin
        if (!r_run2) begin
          w_run2_nxt = 1'b1;
        end else begin
          w_out_nxt   = alu_res;
          w_state_nxt = S_SHOW;
        end
      end
      S_SHOW: begin
        if (w_exec_p) begin
          w_op_nxt    = sw_op;
          w_state_nxt = S_RUN;
        end else if (w_enter_p) begin
          w_opA_nxt   = '0;
          w_opB_nxt   = '0;
          w_nib_nxt   = '0;
          w_state_nxt = S_A;
        end
      end
      default: w_state_nxt = S_A;
    endcase
  end

  always_comb begin
    A4b = r_opA[3:0];
    B4b = r_opB[3:0];
    if (r_state == S_A) A4b = sw_nib;
    if (r_state == S_B) B4b = sw_nib;
  end

  assign opA       = r_opA;
  assign opB       = r_opB;
  assign alu_op    = r_op;
  assign ALU_out   = r_out;
  assign Disp_flag = r_disp;
  assign busy      = (r_state == S_RUN);
  assign state     = r_state;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Randomised and directed bench for alu_operand_entry against a behavioural model.
module tb_alu_operand_entry;

  localparam int DB   = 2;
  localparam int STAB = 1 << DB;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  sw_nib = '0;
  logic [2:0]  sw_op = '0;
  logic [2:0]  btns = '0;
  logic [63:0] alu_res;
  logic [31:0] opA, opB;
  logic [2:0]  alu_op;
  logic [63:0] ALU_out;
  logic [3:0]  A4b, B4b;
  logic        Disp_flag, busy;
  logic [1:0]  state;

  logic        fixed_en = 1'b0;
  logic [63:0] fixed_val = '0;
  logic        cmp_on = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  alu_operand_entry #(.DEB_BITS(DB)) dut (
    .clk(clk), .rstn(rstn), .sw_nib(sw_nib), .sw_op(sw_op),
    .btn_enter(btns[0]), .btn_exec(btns[1]), .btn_page(btns[2]),
    .alu_res(alu_res), .opA(opA), .opB(opB), .alu_op(alu_op), .ALU_out(ALU_out),
    .A4b(A4b), .B4b(B4b), .Disp_flag(Disp_flag), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    logic [31:0] s;
    s = a + b + {29'd0, op};
    return {a ^ b, s};
  endfunction

  assign alu_res = fixed_en ? fixed_val : alu_f(opA, opB, alu_op);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a press is recognised once a button's last STAB synchronised
  // samples all agree and differ from its debounced level.
  logic [STAB:0] m_hist [3];
  logic [2:0]    m_deb;
  logic [31:0]   m_opA, m_opB;
  logic [2:0]    m_op;
  logic [63:0]   m_out;
  logic          m_disp;
  int            m_st, m_cnt, m_rl;

  always @(posedge clk or negedge rstn) begin : ref_model
    logic [2:0]  p, nd;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [63:0] o;
    int          st, cnt, rl;
    if (!rstn) begin
      for (int i = 0; i < 3; i++) m_hist[i] <= '0;
      m_deb <= '0; m_opA <= '0; m_opB <= '0; m_op <= '0; m_out <= '0;
      m_disp <= 1'b0; m_st <= 0; m_cnt <= 0; m_rl <= 0;
    end else begin
      p = '0; nd = m_deb;
      for (int i = 0; i < 3; i++) begin
        if (m_hist[i][STAB:1] == '1 && !m_deb[i]) begin p[i] = 1'b1; nd[i] = 1'b1; end
        else if (m_hist[i][STAB:1] == '0 && m_deb[i]) nd[i] = 1'b0;
      end
      a = m_opA; b = m_opB; op = m_op; o = m_out; st = m_st; cnt = m_cnt; rl = m_rl;
      if (st == 2) begin
        rl = rl - 1;
        if (rl == 0) begin
          o = fixed_en ? fixed_val : alu_f(a, b, op);
          st = 3;
        end
      end else if (p[1]) begin
        op = sw_op; cnt = 0; rl = 2; st = 2;
      end else if (p[0]) begin
        if (st == 3) begin
          a = 0; b = 0; cnt = 0; st = 0;
        end else begin
          if (st == 0) a = a * 16 + {28'd0, sw_nib};
          else         b = b * 16 + {28'd0, sw_nib};
          cnt = cnt + 1;
          if (cnt == 8) begin cnt = 0; if (st == 0) st = 1; end
        end
      end
      for (int i = 0; i < 3; i++) m_hist[i] <= {m_hist[i][STAB-1:0], btns[i]};
      m_deb <= nd; m_opA <= a; m_opB <= b; m_op <= op; m_out <= o;
      m_disp <= m_disp ^ p[2]; m_st <= st; m_cnt <= cnt; m_rl <= rl;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("opA", opA, m_opA);
      chk("opB", opB, m_opB);
      chk("alu_op", alu_op, m_op);
      chk("ALU_out", ALU_out, m_out);
      chk("A4b", A4b, (m_st == 0) ? sw_nib : m_opA[3:0]);
      chk("B4b", B4b, (m_st == 1) ? sw_nib : m_opB[3:0]);
      chk("Disp_flag", Disp_flag, m_disp);
      chk("busy", busy, m_st == 2);
      chk("state", state, m_st[1:0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btns[idx] = 1'b1;
    cyc(8);
    btns[idx] = 1'b0;
    cyc(8);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc(2);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    cmp_on = 1'b1;
    // Reset with bouncing buttons
    for (int i = 0; i < 6; i++) begin
      btns = 3'($urandom_range(0, 7));
      cyc(1);
    end
    chk("rst_opA", opA, 32'h0);
    chk("rst_ALU_out", ALU_out, 64'h0);
    chk("rst_state", state, 2'd0);
    chk("rst_disp", Disp_flag, 1'b0);
    btns = '0;
    rstn = 1'b1;
    cyc(10);
    chk("post_rst_opA", opA, 32'h0);
    chk("post_rst_state", state, 2'd0);

    // Bounce then steady: one pulse, six edges after the level settles
    sw_nib = 4'h5;
    for (int i = 0; i < 10; i++) begin
      btns[0] = (i % 2 == 0);
      cyc(1);
    end
    btns[0] = 1'b1;
    n = 0;
    while (n < 20 && opA != 32'h5) begin
      cyc(1);
      n++;
    end
    chk("deb_latency", 64'(n), 64'd6);
    cyc(6);
    btns[0] = 1'b0;
    cyc(8);
    chk("single_pulse", opA, 32'h5);
    do_reset();

    // Operand entry
    for (int k = 1; k <= 8; k++) begin
      sw_nib = 4'(k);
      press(0);
    end
    chk("opA_full", opA, 32'h12345678);
    chk("to_S_B", state, 2'd1);
    chk("model_opA", m_opA, 32'h12345678);
    for (int k = 0; k < 4; k++) begin
      sw_nib = (k == 3) ? 4'hA : 4'h0;
      press(0);
    end
    chk("opB_part", opB, 32'h0000000A);

    // Run with a fixed result
    fixed_en = 1'b1;
    fixed_val = 64'hDEAD_BEEF_0000_0001;
    sw_op = 3'd3;
    btns[1] = 1'b1;
    n = 0;
    while (n < 20 && !busy) begin
      cyc(1);
      n++;
    end
    chk("alu_op", alu_op, 3'd3);
    n = 0;
    while (n < 20 && busy) begin
      cyc(1);
      n++;
    end
    chk("busy_cycles", 64'(n), 64'd2);
    chk("ALU_out_fixed", ALU_out, 64'hDEAD_BEEF_0000_0001);
    chk("to_S_SHOW", state, 2'd3);
    btns[1] = 1'b0;
    cyc(8);
    press(2);
    chk("page_1", Disp_flag, 1'b1);
    press(2);
    chk("page_0", Disp_flag, 1'b0);

    // Enter in S_SHOW clears operands, keeps result
    sw_nib = 4'h9;
    press(0);
    chk("show_clr_opA", opA, 32'h0);
    chk("show_clr_opB", opB, 32'h0);
    chk("show_keep_out", ALU_out, 64'hDEAD_BEEF_0000_0001);
    chk("show_to_S_A", state, 2'd0);
    press(0);
    chk("opA_9", opA, 32'h9);

    // Enter/exec collision in S_A
    sw_nib = 4'h3;
    btns[1:0] = 2'b11;
    n = 0;
    while (n < 20 && state == 2'd0) begin
      cyc(1);
      n++;
    end
    chk("coll_state", state, 2'd2);
    chk("coll_opA", opA, 32'h9);
    btns[1:0] = 2'b00;
    cyc(8);
    fixed_en = 1'b0;

    // Reset during the first run cycle
    btns[1] = 1'b1;
    n = 0;
    while (n < 20 && !busy) begin
      cyc(1);
      n++;
    end
    rstn = 1'b0;
    #1;
    chk("midrun_out", ALU_out, 64'h0);
    chk("midrun_state", state, 2'd0);
    btns[1] = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc(8);
    sw_nib = 4'h7;
    press(0);
    chk("resume_opA", opA, 32'h7);

    // Random traffic
    for (int it = 0; it < 600; it++) begin
      int r;
      sw_nib = 4'($urandom_range(0, 15));
      sw_op  = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 59);
      if (r == 0) begin
        do_reset();
      end else begin
        if (r < 30)      btns = 3'b001;
        else if (r < 40) btns = 3'b010;
        else if (r < 48) btns = 3'b100;
        else if (r < 54) btns = 3'b011;
        else             btns = 3'($urandom_range(0, 7));
        cyc($urandom_range(1, 12));
        btns = '0;
        cyc($urandom_range(1, 10));
      end
    end
    cyc(4);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
